uart_xcvr: RTL and testbench

// Parametrised full-duplex UART: runtime baud divisor (ubrr), configurable data width and stop bits,

---
 rtl/uart_xcvr_if.sv | 60 ++++++
 rtl/uart_xcvr.sv | 356 +++++++++++++++++++++++++++++++++++
 tb/tb_uart_xcvr.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_xcvr_if.sv
// -----------------------------------------------------------------------------
// uart_xcvr_if
// Bundles the UART transceiver's data-path and control signals so the core and
// its environment connect through one port.
//   slave  : the transceiver side (uart_xcvr)
//   master : the user side (pattern source / display logic / testbench)
// Signals:
//   ubrr        baud divisor, tick every ubrr+1 clocks
//   tx_data     word to send;          tx_valid / tx_ready handshake
//   txd         serial out (idle high); rxd serial in (asynchronous)
//   rx_data     RX FIFO head (fall-through); rx_valid / rx_ready pop handshake
//   rx_level    RX FIFO occupancy
//   rx_overrun  sticky overrun flag;   rx_ovr_clr clears it
//   frame_err   one-cycle pulse on bad stop bit
// Optional (UART_PARITY_EN defined): parity_odd (1 = odd, 0 = even) and
//   parity_err (one-cycle pulse on parity mismatch).
// -----------------------------------------------------------------------------
interface uart_xcvr_if #(
   parameter int DATA_W    = 8,
   parameter int UBRR_W    = 12,
   parameter int RXF_DEPTH = 4
);
   localparam int LVL_W = $clog2(RXF_DEPTH) + 1;

   logic [UBRR_W-1:0] ubrr;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              txd;
   logic              rxd;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic [LVL_W-1:0]  rx_level;
   logic              rx_overrun;
   logic              rx_ovr_clr;
   logic              frame_err;
`ifdef UART_PARITY_EN
   logic              parity_odd;
   logic              parity_err;
`endif

   modport slave (
`ifdef UART_PARITY_EN
      input  parity_odd,
      output parity_err,
`endif
      input  ubrr, tx_data, tx_valid, rxd, rx_ready, rx_ovr_clr,
      output tx_ready, txd, rx_data, rx_valid, rx_level, rx_overrun, frame_err
   );

   modport master (
`ifdef UART_PARITY_EN
      output parity_odd,
      input  parity_err,
`endif
      output ubrr, tx_data, tx_valid, rxd, rx_ready, rx_ovr_clr,
      input  tx_ready, txd, rx_data, rx_valid, rx_level, rx_overrun, frame_err
   );
endinterface

// File: rtl/uart_xcvr.sv
// -----------------------------------------------------------------------------
// uart_xcvr
// Full-duplex UART: shared runtime baud generator (16 ticks per bit), a
// valid/ready transmitter and a receiver feeding a first-word-fall-through
// FIFO with sticky overrun and frame-error reporting.
// Ports:
//   clk  system clock
//   rst  asynchronous, active-low reset
//   bus  uart_xcvr_if.slave (see interface header for the signal list)
// Parameters: DATA_W (5..9), UBRR_W, STOP_BITS (1 or 2, TX only),
//   RXF_DEPTH (power of two >= 2).
// Build option: define UART_PARITY_EN to add a parity bit after the data
//   bits (TX inserts it, RX checks it and drops mismatching words).
// -----------------------------------------------------------------------------
module uart_xcvr #(
   parameter int DATA_W    = 8,
   parameter int UBRR_W    = 12,
   parameter int STOP_BITS = 1,
   parameter int RXF_DEPTH = 4
) (
   input logic        clk,
   input logic        rst,
   uart_xcvr_if.slave bus
);
   localparam int         PTR_W     = $clog2(RXF_DEPTH);
   localparam int         LVL_W     = PTR_W + 1;
   localparam logic [3:0] LAST_TICK = 4'd15;
   localparam logic [3:0] MID_TICK  = 4'd7;
   localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

   // ---------------------------------------------------------------- baud gen
   logic [UBRR_W-1:0] baud_cnt_q;
   logic              tick;

   assign tick = (baud_cnt_q == '0);

   // NOTE: sequential state uses non-blocking assignments so every flop sees
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      baud_cnt_q <= '0;
      else if (tick) baud_cnt_q <= bus.ubrr;   // new divisor lands only on reload
      else           baud_cnt_q <= baud_cnt_q - 1'b1;
   end

   // ---------------------------------------------------------------- TX
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;

   tx_state_e         tx_state_q, tx_state_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic [3:0]        tx_tick_q, tx_tick_d;
   logic [3:0]        tx_bit_q, tx_bit_d;
   logic              tx_sync_q, tx_sync_d;   // first tick after accept seen
   logic              txd_q, txd_d;
`ifdef UART_PARITY_EN
   logic              tx_par_q, tx_par_d;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state_q <= TX_IDLE;
         tx_shift_q <= '0;
         tx_tick_q  <= '0;
         tx_bit_q   <= '0;
         tx_sync_q  <= 1'b0;
         txd_q      <= 1'b1;
`ifdef UART_PARITY_EN
         tx_par_q   <= 1'b0;
`endif
      end else begin
         tx_state_q <= tx_state_d;
         tx_shift_q <= tx_shift_d;
         tx_tick_q  <= tx_tick_d;
         tx_bit_q   <= tx_bit_d;
         tx_sync_q  <= tx_sync_d;
         txd_q      <= txd_d;
`ifdef UART_PARITY_EN
         tx_par_q   <= tx_par_d;
`endif
      end
   end

   always_comb begin
      // NOTE: every combinational output takes its default first, so no path
      // leaves it unassigned and no latch is inferred.
      tx_state_d = tx_state_q;
      tx_shift_d = tx_shift_q;
      tx_tick_d  = tx_tick_q;
      tx_bit_d   = tx_bit_q;
      tx_sync_d  = tx_sync_q;
`ifdef UART_PARITY_EN
      tx_par_d   = tx_par_q;
`endif
      case (tx_state_q)
         TX_IDLE: if (bus.tx_valid) begin
            tx_shift_d = bus.tx_data;
            tx_tick_d  = '0;
            tx_bit_d   = '0;
            // A tick in the accept cycle already counts as the bit's time
            // origin; otherwise the next tick does. Start bit is thus
            // 16 tick periods plus 0..ubrr clocks.
            tx_sync_d  = tick;
            tx_state_d = TX_START;
`ifdef UART_PARITY_EN
            tx_par_d   = (^bus.tx_data) ^ bus.parity_odd;
`endif
         end
         TX_START: if (tick) begin
            if (!tx_sync_q) begin
               tx_sync_d = 1'b1;
            end else if (tx_tick_q == LAST_TICK) begin
               tx_tick_d  = '0;
               tx_state_d = TX_DATA;
            end else begin
               tx_tick_d = tx_tick_q + 1'b1;
            end
         end
         TX_DATA: if (tick) begin
            if (tx_tick_q == LAST_TICK) begin
               tx_tick_d  = '0;
               tx_shift_d = tx_shift_q >> 1;
               if (tx_bit_q == LAST_DATA) begin
                  tx_bit_d = '0;
`ifdef UART_PARITY_EN
                  tx_state_d = TX_PARITY;
`else
                  tx_state_d = TX_STOP;
`endif
               end else begin
                  tx_bit_d = tx_bit_q + 1'b1;
               end
            end else begin
               tx_tick_d = tx_tick_q + 1'b1;
            end
         end
         TX_PARITY: if (tick) begin
            if (tx_tick_q == LAST_TICK) begin
               tx_tick_d  = '0;
               tx_state_d = TX_STOP;
            end else begin
               tx_tick_d = tx_tick_q + 1'b1;
            end
         end
         TX_STOP: if (tick) begin
            if (tx_tick_q == LAST_TICK) begin
               tx_tick_d = '0;
               if (tx_bit_q == LAST_STOP) tx_state_d = TX_IDLE;
               else                       tx_bit_d   = tx_bit_q + 1'b1;
            end else begin
               tx_tick_d = tx_tick_q + 1'b1;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase

      // txd is registered from the next state, so it changes on the same
      // edge as the FSM and carries no combinational glitches.
      txd_d = 1'b1;
      case (tx_state_d)
         TX_START: txd_d = 1'b0;
         TX_DATA:  txd_d = tx_shift_d[0];
`ifdef UART_PARITY_EN
         TX_PARITY: txd_d = tx_par_d;
`endif
         default:  txd_d = 1'b1;
      endcase
   end

   assign bus.tx_ready = (tx_state_q == TX_IDLE);
   assign bus.txd      = txd_q;

   // ---------------------------------------------------------------- RX
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HI} rx_state_e;

   logic [1:0]        rxd_sync_q;
   logic              rxd_prev_q;
   logic              rxd_s;
   logic              rxd_fall;
   rx_state_e         rx_state_q, rx_state_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic [3:0]        rx_tick_q, rx_tick_d;
   logic [3:0]        rx_bit_q, rx_bit_d;
   logic              rx_push;
   logic              frame_err_q, frame_err_d;
`ifdef UART_PARITY_EN
   logic              rx_par_bad_q, rx_par_bad_d;
   logic              parity_err_q, parity_err_d;
`endif

   assign rxd_s    = rxd_sync_q[1];
   assign rxd_fall = rxd_prev_q & ~rxd_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxd_sync_q  <= 2'b11;   // line idles high; no false start out of reset
         rxd_prev_q  <= 1'b1;
         rx_state_q  <= RX_IDLE;
         rx_shift_q  <= '0;
         rx_tick_q   <= '0;
         rx_bit_q    <= '0;
         frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
         rx_par_bad_q <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         rxd_sync_q  <= {rxd_sync_q[0], bus.rxd};
         rxd_prev_q  <= rxd_s;
         rx_state_q  <= rx_state_d;
         rx_shift_q  <= rx_shift_d;
         rx_tick_q   <= rx_tick_d;
         rx_bit_q    <= rx_bit_d;
         frame_err_q <= frame_err_d;
`ifdef UART_PARITY_EN
         rx_par_bad_q <= rx_par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_shift_d  = rx_shift_q;
      rx_tick_d   = rx_tick_q;
      rx_bit_d    = rx_bit_q;
      rx_push     = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad_d = rx_par_bad_q;
      parity_err_d = 1'b0;
`endif
      case (rx_state_q)
         RX_IDLE: if (rxd_fall) begin
            rx_tick_d  = '0;
            rx_state_d = RX_START;
         end
         // Confirm the start bit at its middle; every later sample is then
         // exactly 16 ticks on, i.e. mid-bit.
         RX_START: if (tick) begin
            if (rx_tick_q == MID_TICK) begin
               rx_tick_d  = '0;
               rx_bit_d   = '0;
               rx_state_d = rxd_s ? RX_IDLE : RX_DATA;
            end else begin
               rx_tick_d = rx_tick_q + 1'b1;
            end
         end
         RX_DATA: if (tick) begin
            if (rx_tick_q == LAST_TICK) begin
               rx_tick_d  = '0;
               rx_shift_d = {rxd_s, rx_shift_q[DATA_W-1:1]};
               if (rx_bit_q == LAST_DATA) begin
`ifdef UART_PARITY_EN
                  rx_state_d = RX_PARITY;
`else
                  rx_state_d = RX_STOP;
`endif
               end else begin
                  rx_bit_d = rx_bit_q + 1'b1;
               end
            end else begin
               rx_tick_d = rx_tick_q + 1'b1;
            end
         end
         RX_PARITY: if (tick) begin
            if (rx_tick_q == LAST_TICK) begin
               rx_tick_d  = '0;
`ifdef UART_PARITY_EN
               rx_par_bad_d = rxd_s ^ (^rx_shift_q) ^ bus.parity_odd;
`endif
               rx_state_d = RX_STOP;
            end else begin
               rx_tick_d = rx_tick_q + 1'b1;
            end
         end
         // Returning to IDLE at mid-stop leaves half a bit to catch the
         // next start edge of a back-to-back frame.
         RX_STOP: if (tick) begin
            if (rx_tick_q == LAST_TICK) begin
               rx_tick_d = '0;
               if (rxd_s) begin
`ifdef UART_PARITY_EN
                  parity_err_d = rx_par_bad_q;
                  rx_push      = !rx_par_bad_q;
`else
                  rx_push      = 1'b1;
`endif
                  rx_state_d = RX_IDLE;
               end else begin
                  frame_err_d = 1'b1;
`ifdef UART_PARITY_EN
                  parity_err_d = rx_par_bad_q;
`endif
                  rx_state_d = RX_WAIT_HI;
               end
            end else begin
               rx_tick_d = rx_tick_q + 1'b1;
            end
         end
         // A low stop bit may be a break; wait for the line to recover.
         RX_WAIT_HI: if (rxd_s) rx_state_d = RX_IDLE;
         default:    rx_state_d = RX_IDLE;
      endcase
   end

   assign bus.frame_err = frame_err_q;
`ifdef UART_PARITY_EN
   assign bus.parity_err = parity_err_q;
`endif

   // ---------------------------------------------------------------- RX FIFO
   logic [DATA_W-1:0] fifo_mem [RXF_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]  level_q;
   logic              fifo_full;
   logic              pop;
   logic              push_ok;
   logic              ovr_set;
   logic              overrun_q;

   assign fifo_full = (level_q == LVL_W'(RXF_DEPTH));
   assign pop       = (level_q != '0) && bus.rx_ready;
   assign push_ok   = rx_push && (!fifo_full || pop);
   assign ovr_set   = rx_push && fifo_full && !pop;

   // NOTE: the storage array is not reset; only the pointers and level
   // define which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr_q] <= rx_shift_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;   // wraps mod RXF_DEPTH
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
         // A fresh overrun wins over a simultaneous clear.
         if (ovr_set)             overrun_q <= 1'b1;
         else if (bus.rx_ovr_clr) overrun_q <= 1'b0;
      end
   end

   assign bus.rx_data    = fifo_mem[rd_ptr_q];
   assign bus.rx_valid   = (level_q != '0);
   assign bus.rx_level   = level_q;
   assign bus.rx_overrun = overrun_q;
endmodule

// File: tb/tb_uart_xcvr.sv
// -----------------------------------------------------------------------------
// tb_uart_xcvr
// Self-checking bench for uart_xcvr at ubrr=1 (32 clocks per bit). Received
// words are predicted by a FIFO model and a scoreboard queue; directly driven
// RX frames come from a vector table. Build with UART_PARITY_EN to cover the
// parity option as well.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_xcvr;
   localparam int DATA_W    = 8;
   localparam int UBRR_W    = 12;
   localparam int RXF_DEPTH = 4;
   localparam int STOP_BITS = 1;
   localparam int BIT_CLK   = 32;
`ifdef UART_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   uart_xcvr_if #(.DATA_W(DATA_W), .UBRR_W(UBRR_W), .RXF_DEPTH(RXF_DEPTH)) bus ();

   uart_xcvr #(
      .DATA_W(DATA_W), .UBRR_W(UBRR_W), .STOP_BITS(STOP_BITS), .RXF_DEPTH(RXF_DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic loop_en = 1'b1;
   logic rxd_drv = 1'b1;
   assign bus.rxd = loop_en ? bus.txd : rxd_drv;

   int n_checks = 0;
   int n_pass   = 0;

   // scoreboard and FIFO model
   logic [7:0] exp_q[$];
   int         model_lvl = 0;
   logic       model_ovr = 1'b0;

   // pulse monitors
   int   fe_cnt = 0, fe_long = 0;
   logic fe_prev = 1'b0;
   always @(posedge clk) begin
      if (bus.frame_err) fe_cnt <= fe_cnt + 1;
      if (bus.frame_err && fe_prev) fe_long <= fe_long + 1;
      fe_prev <= bus.frame_err;
   end
`ifdef UART_PARITY_EN
   int   pe_cnt = 0, pe_long = 0;
   logic pe_prev = 1'b0;
   always @(posedge clk) begin
      if (bus.parity_err) pe_cnt <= pe_cnt + 1;
      if (bus.parity_err && pe_prev) pe_long <= pe_long + 1;
      pe_prev <= bus.parity_err;
   end
`endif

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       par_flip;
      int         false_low;   // >0: only pull rxd low this many clocks
      logic       exp_push;
      logic       exp_ferr;
      logic       exp_perr;
   } rx_vec_t;

   localparam int NV = 7;
   rx_vec_t vecs[NV];

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic check_in(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
   endtask

   function automatic logic [15:0] frame_of(input logic [7:0] d, input logic stop);
      logic [15:0] b;
      b      = '1;
      b[0]   = 1'b0;
      b[8:1] = d;
`ifdef UART_PARITY_EN
      b[9]   = (^d) ^ bus.parity_odd;
      b[10]  = stop;
`else
      b[9]   = stop;
`endif
      return b;
   endfunction

   task automatic model_push(input logic [7:0] d);
      if (model_lvl < RXF_DEPTH) begin
         exp_q.push_back(d);
         model_lvl++;
      end else begin
         model_ovr = 1'b1;
      end
   endtask

   task automatic wait_tx_ready();
      int n = 0;
      while (!bus.tx_ready && n < 2000) begin step(1); n++; end
      if (n >= 2000) check("tx_ready_timeout", bus.tx_ready, 1);
   endtask

   task automatic send_byte(input logic [7:0] d);
      wait_tx_ready();
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
      step(1);
      bus.tx_valid = 1'b0;
      if (loop_en) model_push(d);
   endtask

   task automatic pop_check();
      int n = 0;
      logic [7:0] e;
      while (!bus.rx_valid && n < 2000) begin step(1); n++; end
      if (!bus.rx_valid) begin
         check("rx_valid_timeout", bus.rx_valid, 1);
         exp_q.delete();
         model_lvl = 0;
         return;
      end
      e = exp_q.pop_front();
      check("rx_data", bus.rx_data, e);
      bus.rx_ready = 1'b1;
      step(1);
      bus.rx_ready = 1'b0;
      model_lvl--;
   endtask

   task automatic drain();
      while (exp_q.size() > 0) pop_check();
      check("rx_valid_after_drain", bus.rx_valid, 0);
   endtask

   // Send one word and check every txd bit at its middle plus tx_ready timing.
   task automatic tx_wave_check(input logic [7:0] d);
      logic [15:0] bits;
      int elapsed;
      bits = frame_of(d, 1'b1);
      wait_tx_ready();
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
      step(1);
      bus.tx_valid = 1'b0;
      if (loop_en) model_push(d);
      check("accept_tx_ready_low", bus.tx_ready, 0);
      check("accept_txd_low", bus.txd, 0);
      step(BIT_CLK / 2);
      elapsed = BIT_CLK / 2;
      for (int k = 0; k < FRAME_BITS; k++) begin
         check($sformatf("txd_bit%0d_of_%0h", k, d), bus.txd, bits[k]);
         check($sformatf("tx_busy_bit%0d", k), bus.tx_ready, 0);
         if (k < FRAME_BITS - 1) begin
            step(BIT_CLK);
            elapsed += BIT_CLK;
         end
      end
      while (!bus.tx_ready && elapsed < 2000) begin step(1); elapsed++; end
      check_in("tx_ready_return_clk", elapsed, BIT_CLK * FRAME_BITS, BIT_CLK * FRAME_BITS + 1);
   endtask

   task automatic drive_frame(input logic [15:0] bits);
      for (int k = 0; k < FRAME_BITS; k++) begin
         rxd_drv = bits[k];
         step(BIT_CLK);
      end
      rxd_drv = 1'b1;
      step(2 * BIT_CLK);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] bits;
      int fe0;
`ifdef UART_PARITY_EN
      int pe0;
`endif

      vecs[0] = '{8'h55, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{8'h81, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'h00, 1'b1, 1'b0, 8, 1'b0, 1'b0, 1'b0};   // 4-tick glitch
      vecs[3] = '{8'hF0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0};
`ifdef UART_PARITY_EN
      vecs[5] = '{8'h07, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{8'h07, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1};
`else
      vecs[5] = '{8'h07, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{8'h3E, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0};
`endif

      bus.ubrr       = 12'd1;
      bus.tx_data    = '0;
      bus.tx_valid   = 1'b0;
      bus.rx_ready   = 1'b0;
      bus.rx_ovr_clr = 1'b0;
`ifdef UART_PARITY_EN
      bus.parity_odd = 1'b0;
`endif

      // --- reset state
      step(3);
      check("rst_txd", bus.txd, 1);
      check("rst_tx_ready", bus.tx_ready, 1);
      check("rst_rx_valid", bus.rx_valid, 0);
      check("rst_rx_level", bus.rx_level, 0);
      check("rst_rx_overrun", bus.rx_overrun, 0);
      check("rst_frame_err", bus.frame_err, 0);
      rst = 1'b1;
      step(3);

      // --- reset mid-transmit: 0x5A data bit 2 (=0) is on the line at +100
      bus.tx_data  = 8'h5A;
      bus.tx_valid = 1'b1;
      step(1);
      bus.tx_valid = 1'b0;
      step(100);
      check("mid_tx_txd_low", bus.txd, 0);
      rst = 1'b0;
      #1;
      check("midrst_txd", bus.txd, 1);
      check("midrst_tx_ready", bus.tx_ready, 1);
      check("midrst_rx_valid", bus.rx_valid, 0);
      check("midrst_rx_level", bus.rx_level, 0);
      step(5);
      rst = 1'b1;
      step(5);

      // --- 0xA5 waveform, looped back into RX
      tx_wave_check(8'hA5);
      step(20);
      drain();

      // --- back-to-back loopback, FIFO holds both
      send_byte(8'h3C);
      send_byte(8'hC3);
      wait_tx_ready();
      step(20);
      check("b2b_rx_level", bus.rx_level, model_lvl);
      check("b2b_rx_level_two", bus.rx_level, 2);
      drain();

      // --- overrun: five frames into a four-deep FIFO
      for (int i = 1; i <= 5; i++) send_byte(8'(i));
      wait_tx_ready();
      step(20);
      check("ovr_rx_level", bus.rx_level, model_lvl);
      check("ovr_flag", bus.rx_overrun, model_ovr);
      drain();
      check("ovr_sticky", bus.rx_overrun, 1);
      bus.rx_ovr_clr = 1'b1;
      step(1);
      bus.rx_ovr_clr = 1'b0;
      model_ovr = 1'b0;
      check("ovr_cleared", bus.rx_overrun, model_ovr);

      // --- directly driven RX frames from the vector table
      loop_en = 1'b0;
      step(4);
      for (int i = 0; i < NV; i++) begin
         fe0 = fe_cnt;
`ifdef UART_PARITY_EN
         pe0 = pe_cnt;
`endif
         if (vecs[i].false_low > 0) begin
            rxd_drv = 1'b0;
            step(vecs[i].false_low);
            rxd_drv = 1'b1;
            step(2 * BIT_CLK);
         end else begin
            bits = frame_of(vecs[i].data, vecs[i].stop);
`ifdef UART_PARITY_EN
            bits[9] = bits[9] ^ vecs[i].par_flip;
`endif
            drive_frame(bits);
         end
         if (vecs[i].exp_push) model_push(vecs[i].data);
         check($sformatf("vec%0d_frame_err_pulses", i), 32'(fe_cnt - fe0), 32'(vecs[i].exp_ferr));
         check($sformatf("vec%0d_rx_level", i), bus.rx_level, model_lvl);
`ifdef UART_PARITY_EN
         check($sformatf("vec%0d_parity_err_pulses", i), 32'(pe_cnt - pe0), 32'(vecs[i].exp_perr));
`endif
      end
      drain();
      check("frame_err_single_cycle", fe_long, 0);
`ifdef UART_PARITY_EN
      check("parity_err_single_cycle", pe_long, 0);
      // parity bit of 0x07 under even parity is 1, checked on the wire
      loop_en = 1'b1;
      step(4);
      tx_wave_check(8'h07);
      step(20);
      drain();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
